// File: rtl/game_pkg.sv
// Shared encodings and default timing for the whack-a-mole phase sequencer.
package game_pkg;

  localparam int unsigned DISP_W          = 32;
  localparam int unsigned SECS_W          = 6;
  localparam int unsigned DEF_CLK_HZ      = 100_000_000;
  localparam int unsigned DEF_COUNTDOWN_S = 5;
  localparam int unsigned DEF_GAME_S      = 30;

  typedef enum logic [1:0] {
    PH_IDLE      = 2'd0,
    PH_COUNTDOWN = 2'd1,
    PH_PLAY      = 2'd2,
    PH_DONE      = 2'd3
  } phase_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/game_phase_ctrl.sv
// Whack-a-mole sequencer: IDLE -> countdown -> timed play with scoring -> game over.
module game_phase_ctrl #(
  parameter int unsigned CLK_HZ      = game_pkg::DEF_CLK_HZ,
  parameter int unsigned COUNTDOWN_S = game_pkg::DEF_COUNTDOWN_S,
  parameter int unsigned GAME_S      = game_pkg::DEF_GAME_S
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hit,
  output logic        game_begin,
  output logic [1:0]  phase,
  output logic [31:0] display_value,
  output logic [5:0]  time_left,
  output logic        mole_enable,
  output logic        game_over
);

  import game_pkg::*;

  localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(CLK_HZ - 1);
  localparam logic [SECS_W-1:0]  SECS_CD     = SECS_W'(COUNTDOWN_S);
  localparam logic [SECS_W-1:0]  SECS_GAME   = SECS_W'(GAME_S);

  logic w_start_pulse;
  logic w_hit_pulse;
  logic w_counting;
  logic w_tick;

  phase_e              r_state, w_state_d;
  logic [PRESC_W-1:0]  r_presc, w_presc_d;
  logic [SECS_W-1:0]   r_secs, w_secs_d;
  logic [DISP_W-1:0]   r_score, w_score_d;

  logic [DISP_W-1:0]   r_disp, w_disp_d;
  logic [SECS_W-1:0]   r_time_left, w_time_left_d;
  logic                r_game_begin, r_mole, r_over;

  sync_edge_detect u_start_sync (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .pulse (w_start_pulse)
  );

  sync_edge_detect u_hit_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hit),
    .pulse (w_hit_pulse)
  );

  assign w_counting = (r_state == PH_COUNTDOWN) || (r_state == PH_PLAY);
  assign w_tick     = w_counting && (r_presc == PRESC_MAX);

  always_comb begin
    w_state_d = r_state;
    w_secs_d  = r_secs;
    w_score_d = r_score;
    // Prescaler rests at 0 outside timed phases, so every timed phase starts a full second.
    if (!w_counting || w_tick) w_presc_d = '0;
    else                       w_presc_d = r_presc + 1'b1;

    case (r_state)
      PH_IDLE, PH_DONE: begin
        if (w_start_pulse) begin
          w_state_d = PH_COUNTDOWN;
          w_secs_d  = SECS_CD;
          w_presc_d = '0;
        end
      end
      PH_COUNTDOWN: begin
        if (w_tick) begin
          if (r_secs > 1) begin
            w_secs_d = r_secs - 1'b1;
          end else begin
            w_state_d = PH_PLAY;
            w_secs_d  = SECS_GAME;
            w_score_d = '0;
          end
        end
      end
      PH_PLAY: begin
        // A hit landing on the final tick still counts.
        if (w_hit_pulse && (r_score != '1)) w_score_d = r_score + 1'b1;
        if (w_tick) begin
          if (r_secs > 1) begin
            w_secs_d = r_secs - 1'b1;
          end else begin
            w_state_d = PH_DONE;
            w_secs_d  = '0;
          end
        end
      end
      default: w_state_d = PH_IDLE;
    endcase

    // Outputs are derived from next state so they update on the same edge as phase.
    case (w_state_d)
      PH_COUNTDOWN:     w_disp_d = {{(DISP_W - SECS_W){1'b0}}, w_secs_d};
      PH_PLAY, PH_DONE: w_disp_d = w_score_d;
      default:          w_disp_d = '0;
    endcase
    w_time_left_d = (w_state_d == PH_PLAY) ? w_secs_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= PH_IDLE;
      r_presc      <= '0;
      r_secs       <= '0;
      r_score      <= '0;
      r_disp       <= '0;
      r_time_left  <= '0;
      r_game_begin <= 1'b0;
      r_mole       <= 1'b0;
      r_over       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_presc      <= w_presc_d;
      r_secs       <= w_secs_d;
      r_score      <= w_score_d;
      r_disp       <= w_disp_d;
      r_time_left  <= w_time_left_d;
      r_game_begin <= (w_state_d == PH_PLAY) || (w_state_d == PH_DONE);
      r_mole       <= (w_state_d == PH_PLAY);
      r_over       <= (w_state_d == PH_DONE);
    end
  end

  assign phase         = r_state;
  assign display_value = r_disp;
  assign time_left     = r_time_left;
  assign game_begin    = r_game_begin;
  assign mole_enable   = r_mole;
  assign game_over     = r_over;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl with a 10-cycle second, 5 s countdown and 30 s play.
module tb_game_phase_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        hit;
  logic        game_begin;
  logic [1:0]  phase;
  logic [31:0] display_value;
  logic [5:0]  time_left;
  logic        mole_enable;
  logic        game_over;

  int pass_cnt;
  int total_cnt;

  game_phase_ctrl #(
    .CLK_HZ      (10),
    .COUNTDOWN_S (5),
    .GAME_S      (30)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .hit           (hit),
    .game_begin    (game_begin),
    .phase         (phase),
    .display_value (display_value),
    .time_left     (time_left),
    .mole_enable   (mole_enable),
    .game_over     (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    hit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      total_cnt++;
      if ({phase, game_begin, display_value, time_left, mole_enable, game_over} !== 42'd0)
        $display("FAIL reset_outputs cyc %0d: got phase=%0d disp=%0d tl=%0d gb=%0b me=%0b go=%0b want all 0",
                 i, phase, display_value, time_left, game_begin, mole_enable, game_over);
      else pass_cnt++;
    end
    start = 1'b0;
    hit   = 1'b0;
    step(1);
    reset = 1'b1;
    step(5);
    total_cnt++;
    if (phase !== 2'd0) $display("FAIL reset_release_idle: got %0d want 0", phase);
    else pass_cnt++;
  endtask

  task automatic test_countdown();
    start = 1'b1;
    step(2);
    total_cnt++;
    if (phase !== 2'd0) $display("FAIL start_latency_early: got %0d want 0", phase);
    else pass_cnt++;
    step(1);
    for (int v = 5; v >= 1; v--) begin
      total_cnt++;
      if (phase !== 2'd1 || display_value !== 32'(v) || game_begin !== 1'b0 || time_left !== 6'd0)
        $display("FAIL cd_first_%0d: got phase=%0d disp=%0d gb=%0b tl=%0d want 1/%0d/0/0",
                 v, phase, display_value, game_begin, time_left, v);
      else pass_cnt++;
      if (v == 4) start = 1'b0;
      step(9);
      total_cnt++;
      if (display_value !== 32'(v))
        $display("FAIL cd_last_%0d: got %0d want %0d", v, display_value, v);
      else pass_cnt++;
      step(1);
    end
    total_cnt++;
    if (phase !== 2'd2 || game_begin !== 1'b1 || mole_enable !== 1'b1 ||
        time_left !== 6'd30 || display_value !== 32'd0 || game_over !== 1'b0)
      $display("FAIL play_entry: got phase=%0d gb=%0b me=%0b tl=%0d disp=%0d go=%0b want 2/1/1/30/0/0",
               phase, game_begin, mole_enable, time_left, display_value, game_over);
    else pass_cnt++;
  endtask

  // Returns with 56 edges elapsed since PLAY entry.
  task automatic test_hits();
    for (int i = 0; i < 7; i++) begin
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      step(3);
    end
    total_cnt++;
    if (display_value !== 32'd7) $display("FAIL hit_pulses: got %0d want 7", display_value);
    else pass_cnt++;
    hit = 1'b1;
    step(25);
    hit = 1'b0;
    step(3);
    total_cnt++;
    if (display_value !== 32'd8) $display("FAIL hit_held: got %0d want 8", display_value);
    else pass_cnt++;
    total_cnt++;
    if (time_left !== 6'd25) $display("FAIL time_left_mid: got %0d want 25", time_left);
    else pass_cnt++;
  endtask

  task automatic test_play_end();
    start = 1'b1;
    step(3);
    start = 1'b0;
    step(1);
    total_cnt++;
    if (phase !== 2'd2) $display("FAIL start_in_play: got %0d want 2", phase);
    else pass_cnt++;
    step(237);
    total_cnt++;
    if (phase !== 2'd2 || time_left !== 6'd1)
      $display("FAIL play_last_sec: got phase=%0d tl=%0d want 2/1", phase, time_left);
    else pass_cnt++;
    // Pin rises before edge 298 so its pulse lands on the final tick at edge 300.
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    step(1);
    total_cnt++;
    if (phase !== 2'd2 || display_value !== 32'd8)
      $display("FAIL pre_final_tick: got phase=%0d disp=%0d want 2/8", phase, display_value);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (phase !== 2'd3 || game_over !== 1'b1 || time_left !== 6'd0 || mole_enable !== 1'b0 ||
        game_begin !== 1'b1 || display_value !== 32'd9)
      $display("FAIL done_entry: got phase=%0d go=%0b tl=%0d me=%0b gb=%0b disp=%0d want 3/1/0/0/1/9",
               phase, game_over, time_left, mole_enable, game_begin, display_value);
    else pass_cnt++;
  endtask

  task automatic test_done_hits();
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      step(3);
    end
    total_cnt++;
    if (phase !== 2'd3 || display_value !== 32'd9)
      $display("FAIL done_hits_ignored: got phase=%0d disp=%0d want 3/9", phase, display_value);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    start = 1'b1;
    step(3);
    start = 1'b0;
    total_cnt++;
    if (phase !== 2'd1 || display_value !== 32'd5 || game_begin !== 1'b0 || game_over !== 1'b0)
      $display("FAIL restart_cd: got phase=%0d disp=%0d gb=%0b go=%0b want 1/5/0/0",
               phase, display_value, game_begin, game_over);
    else pass_cnt++;
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    total_cnt++;
    if (phase !== 2'd1 || display_value !== 32'd5)
      $display("FAIL start_in_cd: got phase=%0d disp=%0d want 1/5", phase, display_value);
    else pass_cnt++;
    step(40);
    total_cnt++;
    if (phase !== 2'd1 || display_value !== 32'd1)
      $display("FAIL restart_cd_end: got phase=%0d disp=%0d want 1/1", phase, display_value);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (phase !== 2'd2 || display_value !== 32'd0 || time_left !== 6'd30)
      $display("FAIL score_cleared: got phase=%0d disp=%0d tl=%0d want 2/0/30",
               phase, display_value, time_left);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_play();
    step(15);
    hit = 1'b1;
    step(1);
    hit = 1'b0;
    step(3);
    total_cnt++;
    if (display_value !== 32'd1) $display("FAIL replay_hit: got %0d want 1", display_value);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({phase, game_begin, display_value, time_left, mole_enable, game_over} !== 42'd0)
      $display("FAIL async_reset: got phase=%0d disp=%0d tl=%0d gb=%0b me=%0b go=%0b want all 0",
               phase, display_value, time_left, game_begin, mole_enable, game_over);
    else pass_cnt++;
    step(3);
    reset = 1'b1;
    step(5);
    total_cnt++;
    if (phase !== 2'd0 || display_value !== 32'd0)
      $display("FAIL post_reset_idle: got phase=%0d disp=%0d want 0/0", phase, display_value);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b0;
    start     = 1'b0;
    hit       = 1'b0;
    test_reset();
    test_countdown();
    test_hits();
    test_play_end();
    test_done_hits();
    test_restart();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
